// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter, checker and receiver.
package parity_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FRAME_BITS = 35;
    localparam int unsigned IDX_W      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: one-cycle tick when the count reaches CLKS_PER_BIT-1.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count within a bit period; clear holds it at zero and restarts it on state entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 32 data bits LSB first, parity, stop.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          ODD_PARITY   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              parity_bit,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_d, ready_d, busy_d, done_d, overrun_d;
    logic              baud_clear_c;
    logic              tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear_c),
        .tick  (tick)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx      <= tx_d;
            ready   <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
            overrun <= overrun_d;
        end
    end

    // Next-state and next-output logic; bit boundaries are the baud ticks
    always_comb begin
        state_d      = state;
        shift_d      = shift_q;
        idx_d        = idx_q;
        par_d        = par_q;
        tx_d         = tx;
        ready_d      = ready;
        busy_d       = busy;
        done_d       = 1'b0;
        overrun_d    = data_valid && !ready;

        unique case (state)
            IDLE: begin
                if (data_valid) begin
                    shift_d = data;
                    par_d   = parity_bit ^ ODD_PARITY;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Divider restarts on every state entry and is held at zero in IDLE
        baud_clear_c = (state_d != state) || (state == IDLE);
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: even- and odd-parity instances against a frame model.
module tb_parity_frame_tx;

    localparam int C  = 4;
    localparam int FL = 35 * C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data = '0;
    logic        parity_bit = 1'b0;

    logic tx0, ready0, busy0, done0, ovr0;
    logic tx1, ready1, busy1, done1, ovr1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .parity_bit(parity_bit),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    parity_frame_tx #(.CLKS_PER_BIT(C), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .parity_bit(parity_bit),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    // Frame as a bit-slot list: slot 0 start, 1..32 data LSB first, 33 parity, 34 stop
    function automatic logic [34:0] make_frame(input logic [31:0] w, input logic p, input logic odd);
        return {1'b1, p ^ odd, w, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total += 2;
            if ({tx0, ready0, busy0, done0, ovr0} !== 5'b11000) begin
                bad++; $display("FAIL reset_even cyc=%0d got=%b exp=11000", i, {tx0, ready0, busy0, done0, ovr0});
            end
            if ({tx1, ready1, busy1, done1, ovr1} !== 5'b11000) begin
                bad++; $display("FAIL reset_odd cyc=%0d got=%b exp=11000", i, {tx1, ready1, busy1, done1, ovr1});
            end
        end
    endtask

    // Single frame; done must land exactly FL cycles after acceptance
    task automatic test_frame(input string name, input logic [31:0] w, input logic p);
        logic [34:0] f0, f1;
        f0 = make_frame(w, p, 1'b0);
        f1 = make_frame(w, p, 1'b1);
        @(negedge clk);
        data_valid = 1'b1; data = w; parity_bit = p;
        @(negedge clk);
        data_valid = 1'b0; data = $urandom; parity_bit = 1'($urandom);
        for (int j = 0; j < FL; j++) begin
            total += 3;
            if (tx0 !== f0[j/C]) begin bad++; $display("FAIL %s_tx_even j=%0d got=%b exp=%b", name, j, tx0, f0[j/C]); end
            if (tx1 !== f1[j/C]) begin bad++; $display("FAIL %s_tx_odd j=%0d got=%b exp=%b", name, j, tx1, f1[j/C]); end
            if ({busy0, ready0, done0, ovr0, busy1, ready1, done1, ovr1} !== 8'b10001000) begin
                bad++; $display("FAIL %s_status j=%0d got=%b exp=10001000", name, j,
                                {busy0, ready0, done0, ovr0, busy1, ready1, done1, ovr1});
            end
            @(negedge clk);
        end
        total += 2;
        if ({tx0, busy0, ready0, done0, ovr0, tx1, busy1, ready1, done1, ovr1} !== 10'b1011010110) begin
            bad++; $display("FAIL %s_end got=%b exp=1011010110", name,
                            {tx0, busy0, ready0, done0, ovr0, tx1, busy1, ready1, done1, ovr1});
        end
        @(negedge clk);
        if ({tx0, busy0, ready0, done0, tx1, busy1, ready1, done1} !== 8'b10101010) begin
            bad++; $display("FAIL %s_after got=%b exp=10101010", name,
                            {tx0, busy0, ready0, done0, tx1, busy1, ready1, done1});
        end
    endtask

    task automatic test_single_bit();
        test_frame("single_bit", 32'h0000_0001, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        p;
        for (int n = 0; n < 5; n++) begin
            w = $urandom;
            p = ($urandom_range(0, 3) == 0) ? ~(^w) : ^w;
            test_frame("random", w, p);
        end
    endtask

    // Mid-bit sampling of the odd-parity line rebuilds the word and the parity slot
    task automatic test_odd_parity();
        logic [31:0] rec;
        logic        par;
        logic [34:0] f1;
        rec = '0;
        par = 1'b0;
        f1  = make_frame(32'hA5A5_A5A5, 1'b0, 1'b1);
        @(negedge clk);
        data_valid = 1'b1; data = 32'hA5A5_A5A5; parity_bit = 1'b0;
        @(negedge clk);
        data_valid = 1'b0;
        for (int j = 0; j < FL; j++) begin
            if (j % C == C / 2) begin
                if (j / C >= 1 && j / C <= 32) rec[j/C-1] = tx1;
                if (j / C == 33) par = tx1;
            end
            total++;
            if (tx1 !== f1[j/C]) begin bad++; $display("FAIL odd_tx j=%0d got=%b exp=%b", j, tx1, f1[j/C]); end
            @(negedge clk);
        end
        total += 3;
        if (rec !== 32'hA5A5_A5A5) begin bad++; $display("FAIL odd_word got=%h exp=a5a5a5a5", rec); end
        if (par !== 1'b1) begin bad++; $display("FAIL odd_parity_slot got=%b exp=1", par); end
        if ({done1, ready1} !== 2'b11) begin bad++; $display("FAIL odd_done got=%b exp=11", {done1, ready1}); end
        @(negedge clk);
    endtask

    // data_valid held high: second frame begins the cycle after done
    task automatic test_back_to_back();
        logic [31:0] w [2];
        logic [34:0] f;
        w[0] = 32'hFFFF_FFFF;
        w[1] = 32'h0000_0000;
        @(negedge clk);
        data_valid = 1'b1; data = w[0]; parity_bit = ^w[0];
        @(negedge clk);
        data = w[1]; parity_bit = ^w[1];
        for (int k = 0; k < 2; k++) begin
            f = make_frame(w[k], ^w[k], 1'b0);
            for (int j = 0; j < FL; j++) begin
                total += 2;
                if (tx0 !== f[j/C]) begin bad++; $display("FAIL b2b_tx frame=%0d j=%0d got=%b exp=%b", k, j, tx0, f[j/C]); end
                if ({busy0, ready0, done0} !== 3'b100) begin
                    bad++; $display("FAIL b2b_status frame=%0d j=%0d got=%b exp=100", k, j, {busy0, ready0, done0});
                end
                @(negedge clk);
                if (k == 1 && j == 0) data_valid = 1'b0;
            end
            total++;
            if ({tx0, busy0, ready0, done0} !== 4'b1011) begin
                bad++; $display("FAIL b2b_end frame=%0d got=%b exp=1011", k, {tx0, busy0, ready0, done0});
            end
            @(negedge clk);
        end
        total++;
        if ({tx0, busy0, ready0, done0, ovr0} !== 5'b10100) begin
            bad++; $display("FAIL b2b_idle got=%b exp=10100", {tx0, busy0, ready0, done0, ovr0});
        end
    endtask

    // Second word 10 cycles in is dropped with a single overrun pulse
    task automatic test_overrun();
        logic [31:0] w;
        logic        p;
        logic [34:0] f;
        int          pulses;
        w = $urandom;
        p = ^w;
        f = make_frame(w, p, 1'b0);
        pulses = 0;
        @(negedge clk);
        data_valid = 1'b1; data = w; parity_bit = p;
        @(negedge clk);
        data_valid = 1'b0;
        for (int j = 0; j < FL; j++) begin
            if (ovr0 === 1'b1) pulses++;
            total += 3;
            if (tx0 !== f[j/C]) begin bad++; $display("FAIL ovr_tx j=%0d got=%b exp=%b", j, tx0, f[j/C]); end
            if (ovr0 !== (j == 10)) begin bad++; $display("FAIL ovr_pulse j=%0d got=%b exp=%b", j, ovr0, (j == 10)); end
            if (ovr1 !== (j == 10)) begin bad++; $display("FAIL ovr_pulse_odd j=%0d got=%b exp=%b", j, ovr1, (j == 10)); end
            if (j == 9) begin
                data_valid = 1'b1; data = ~w; parity_bit = ~p;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        total += 2;
        if (pulses != 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", pulses); end
        if ({tx0, done0, ready0} !== 3'b111) begin bad++; $display("FAIL ovr_end got=%b exp=111", {tx0, done0, ready0}); end
        @(negedge clk);
    endtask

    // Asynchronous reset 50 cycles into a frame, then a clean frame
    task automatic test_reset_mid_frame();
        logic [31:0] w;
        logic [34:0] f;
        w = $urandom;
        f = make_frame(w, ^w, 1'b0);
        @(negedge clk);
        data_valid = 1'b1; data = w; parity_bit = ^w;
        @(negedge clk);
        data_valid = 1'b0;
        for (int j = 0; j < 50; j++) begin
            total++;
            if (tx0 !== f[j/C]) begin bad++; $display("FAIL rstmid_tx j=%0d got=%b exp=%b", j, tx0, f[j/C]); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        total += 2;
        if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
            bad++; $display("FAIL rstmid_async got=%b exp=1100", {tx0, ready0, busy0, done0});
        end
        if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
            bad++; $display("FAIL rstmid_async_odd got=%b exp=1100", {tx1, ready1, busy1, done1});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
                bad++; $display("FAIL rstmid_hold cyc=%0d got=%b exp=1100", i, {tx0, ready0, busy0, done0});
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({tx0, ready0, busy0, done0} !== 4'b1100) begin
                bad++; $display("FAIL rstmid_idle cyc=%0d got=%b exp=1100", i, {tx0, ready0, busy0, done0});
            end
        end
        test_frame("after_reset", $urandom, 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_odd_parity();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter directly downstream of the parity generator. It captures a 32-bit word and its parity bit when the generator signals completion, then shifts out one frame on a single line: start bit, 32 data bits LSB first, parity bit, stop bit. Bit timing comes from a fixed clock divider. It sits between the AXI-fed parity stage and the board-level serial output pin.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- ODD_PARITY, 0: 0 transmits parity_bit as received; 1 transmits ~parity_bit.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_valid  input  1  word and parity are available; driven by the parity generator's done.
- data  input  32  word to transmit; stable while data_valid=1.
- parity_bit  input  1  even parity (^data) from the generator.
- ready  output  1  1 in IDLE; a data_valid seen while ready=1 is accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  1 while a frame is in flight (START..STOP).
- done  output  1  single-cycle pulse when the stop bit completes.
- overrun  output  1  single-cycle pulse when data_valid arrives while ready=0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0, overrun=0, shift register=0, counters=0.
- IDLE: on data_valid=1, capture data into a 32-bit shift register and store par = parity_bit ^ ODD_PARITY. Then go to START with tx<=0, ready<=0, busy<=1.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
- DATA: each bit is held CLKS_PER_BIT cycles. Shift right at each bit boundary. A 5-bit index counts 0..31. After bit 31 completes, go to PARITY with tx<=par.
- PARITY: hold for CLKS_PER_BIT cycles, then go to STOP with tx<=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. Then go to IDLE with ready<=1, busy<=0, done<=1 for one cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and resets to 0 on every state entry and every bit boundary. It never free-runs in IDLE.
- data_valid while ready=0: the word is dropped and overrun pulses for one cycle. The frame in flight is unaffected.
- data_valid held high across the return to IDLE: a new frame is accepted on the first cycle ready=1. There are no idle gaps beyond that cycle.
- Reset asserted mid-frame: all state returns immediately (asynchronously) to reset values and tx goes high. The partial frame is abandoned and done is not pulsed.
- tx, ready, busy, done and overrun are all registered. No combinational path runs from inputs to outputs.

## Timing
- Accept edge N (data_valid=1, ready=1): tx=0 and busy=1 are visible after edge N.
- Frame length is 35*CLKS_PER_BIT cycles from edge N to the edge that raises done and ready.
- Data bit k occupies cycles N+(1+k)*CLKS_PER_BIT to N+(2+k)*CLKS_PER_BIT-1, relative to edge N.
- Parity occupies bit slot 33 and stop occupies bit slot 34.
- Back-to-back throughput: one frame per 35*CLKS_PER_BIT+1 cycles when data_valid is held high.
- With the parity generator upstream: generator start at edge M gives data_valid at edge M+1, so the frame begins at M+1.

## Structure
- Shared package parity_pkg holds the following, so the checker and receiver can reuse them:
  - the state encoding typedef (tx_state_t: IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS=35;
  - DATA_W=32.
- One sub-module, baud_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick). It is a counter producing a one-cycle tick at CLKS_PER_BIT-1. The FSM asserts clear on each state entry.

## Test plan
- Reset with CLKS_PER_BIT=4, no stimulus: tx=1, ready=1, busy=0, done=0, overrun=0 for 100 cycles.
- data=0x0000_0001, parity_bit=1, ODD_PARITY=0: tx sees 0 (4 cycles), then 1 (4 cycles), then 31 zeros (124 cycles), then 1 (parity, 4 cycles), then 1 (stop, 4 cycles). done pulses once at cycle 140 after acceptance.
- data=0xA5A5_A5A5, parity_bit=0, ODD_PARITY=1: the sampled mid-bit data reconstructs 0xA5A5A5A5 and the parity slot is 1.
- data_valid held high with two words, 0xFFFF_FFFF and 0x0000_0000: two contiguous frames with exactly one idle-high cycle between them. The second frame starts the cycle after done.
- data_valid pulsed 10 cycles into a frame: overrun pulses once, and the first frame completes unchanged.
- rst driven low at cycle 50 of a frame, released 3 cycles later: tx=1 and ready=1 immediately, with no done pulse. The next accepted word transmits a correct full frame.
